// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath blocks.
package systolic_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_N_RES  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/result_drain.sv
// Captures a full row of accumulator results on en_y and streams them out
// one word at a time over a valid/ready interface. A new row may be chained
// in on the final handshake without a bubble; any other en_y while draining
// is dropped and recorded in the sticky overrun flag.
module result_drain
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int N_RES  = DEFAULT_N_RES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_y,
    input  logic [N_RES*DATA_W-1:0] acc_in,
    output logic [DATA_W-1:0]       y_data,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic                    y_last,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    clr_overrun
);

    localparam int IDX_W = $clog2(N_RES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RES - 1);

    drain_state_t      state;
    drain_state_t      state_next;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] res_buf [N_RES];

    logic in_drain;
    logic handshake;
    logic at_last;
    logic capture;
    logic overrun_set;

    assign in_drain    = (state == DRAIN);
    assign handshake   = in_drain && y_ready;
    assign at_last     = (idx == LAST_IDX);
    assign capture     = ((state == IDLE) && en_y) || (handshake && at_last && en_y);
    assign overrun_set = in_drain && en_y && !(handshake && at_last);

    assign y_valid = in_drain;
    assign y_data  = in_drain ? res_buf[idx] : '0;
    assign y_last  = in_drain && at_last;
    assign busy    = in_drain;

    // State register; reset abandons any drain in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave DRAIN only on the final handshake with no chained capture.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en_y) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && at_last && !en_y) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Word index: restarts on capture, otherwise advances only on a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if (handshake) begin
            idx <= at_last ? '0 : idx + IDX_W'(1);
        end
    end

    // Result buffer: loaded only on an accepted capture, never by a dropped en_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_RES; i++) begin
                res_buf[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N_RES; i++) begin
                res_buf[i] <= acc_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Sticky overrun flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: every accepted capture pushes its words
// to a queue, and every handshake pops and compares data and the last flag.
module tb_result_drain;

    localparam int DATA_W = 32;
    localparam int N_RES  = 8;

    logic                    clk;
    logic                    reset;
    logic                    en_y;
    logic [N_RES*DATA_W-1:0] acc_in;
    logic [DATA_W-1:0]       y_data;
    logic                    y_valid;
    logic                    y_ready;
    logic                    y_last;
    logic                    busy;
    logic                    overrun;
    logic                    clr_overrun;

    logic [DATA_W:0] exp_q [$];
    int tests_run;
    int tests_failed;

    result_drain #(
        .DATA_W(DATA_W),
        .N_RES (N_RES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_y       (en_y),
        .acc_in     (acc_in),
        .y_data     (y_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_last     (y_last),
        .busy       (busy),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive a row of words base..base+N_RES-1 with an en_y pulse; push to the
    // scoreboard only when the bench expects the DUT to accept the capture.
    task automatic applyStimulus(input int base, input bit expect_capture);
        for (int i = 0; i < N_RES; i++) begin
            acc_in[i*DATA_W +: DATA_W] = DATA_W'(base + i);
            if (expect_capture) begin
                exp_q.push_back({(i == N_RES - 1), DATA_W'(base + i)});
            end
        end
        en_y = 1'b1;
    endtask

    // Check any handshake about to happen, then advance to 1 time unit past the next edge.
    task automatic tick();
        logic [DATA_W:0] exp_word;
        if (y_valid && y_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word", {31'd0, y_last, y_data}, 64'hDEAD);
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("y_data", 64'(y_data), 64'(exp_word[DATA_W-1:0]));
                checkOutput("y_last", 64'(y_last), 64'(exp_word[DATA_W]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 64'(y_valid), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_data"}, 64'(y_data), 64'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        en_y         = 1'b0;
        acc_in       = '0;
        y_ready      = 1'b0;
        clr_overrun  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 64'(y_valid), 64'd0);
        checkOutput("rst_last", 64'(y_last), 64'd0);
        checkOutput("rst_data", 64'(y_data), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        tick();

        // Full-rate drain of words 1..8.
        y_ready = 1'b1;
        applyStimulus(1, 1'b1);
        tick();
        en_y = 1'b0;
        checkOutput("latency_valid", 64'(y_valid), 64'd1);
        checkOutput("latency_data", 64'(y_data), 64'd1);
        for (int i = 0; i < N_RES; i++) begin
            checkOutput("stream_valid", 64'(y_valid), 64'd1);
            tick();
        end
        checkIdle("after_stream");

        // Backpressure at idx 2 for three cycles.
        applyStimulus(1, 1'b1);
        tick();
        en_y = 1'b0;
        tick();
        tick();
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_valid", 64'(y_valid), 64'd1);
            checkOutput("stall_data", 64'(y_data), 64'd3);
            checkOutput("stall_last", 64'(y_last), 64'd0);
            tick();
        end
        y_ready = 1'b1;
        for (int i = 0; i < N_RES - 2; i++) tick();
        checkIdle("after_stall");

        // Dropped en_y at idx 4; clear requested in the same cycle must lose.
        applyStimulus(1, 1'b1);
        tick();
        en_y = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(101, 1'b0);
        clr_overrun = 1'b1;
        tick();
        en_y        = 1'b0;
        clr_overrun = 1'b0;
        checkOutput("overrun_set", 64'(overrun), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        checkIdle("after_overrun");
        checkOutput("overrun_sticky", 64'(overrun), 64'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checkOutput("overrun_clr", 64'(overrun), 64'd0);

        // Back-to-back chaining on the last handshake.
        applyStimulus(1, 1'b1);
        tick();
        en_y = 1'b0;
        for (int i = 0; i < N_RES - 1; i++) tick();
        checkOutput("chain_at_last", 64'(y_last), 64'd1);
        applyStimulus(9, 1'b1);
        tick();
        en_y = 1'b0;
        checkOutput("chain_valid", 64'(y_valid), 64'd1);
        checkOutput("chain_data", 64'(y_data), 64'd9);
        checkOutput("chain_overrun", 64'(overrun), 64'd0);
        for (int i = 0; i < N_RES; i++) tick();
        checkIdle("after_chain");

        // Reset in the middle of a drain at idx 5.
        applyStimulus(1, 1'b1);
        tick();
        en_y = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("pre_reset_data", 64'(y_data), 64'd6);
        reset = 1'b1;
        #1;
        checkIdle("mid_reset");
        checkOutput("mid_reset_last", 64'(y_last), 64'd0);
        checkOutput("mid_reset_overrun", 64'(overrun), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_reset_valid", 64'(y_valid), 64'd0);
        end
        checkIdle("post_reset");

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of one accumulator result word.
REQ-002 The block SHALL have parameter N_RES, default 8, meaning the number of results captured per en_y pulse (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en_y, input, 1 bit: single-cycle pulse meaning the accumulator results are final.
REQ-006 The block SHALL have port acc_in, input, N_RES*DATA_W bits: accumulator results, with word i at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port y_data, output, DATA_W bits: the result word currently offered.
REQ-008 The block SHALL have port y_valid, output, 1 bit: y_data is valid.
REQ-009 The block SHALL have port y_ready, input, 1 bit: the downstream sink accepts the word.
REQ-010 The block SHALL have port y_last, output, 1 bit: the offered word is word N_RES-1.
REQ-011 The block SHALL have port busy, output, 1 bit: the block is in DRAIN.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag meaning an en_y pulse was dropped.
REQ-013 The block SHALL have port clr_overrun, input, 1 bit: synchronous clear of overrun.

Function
REQ-014 The block SHALL implement a two-state FSM with states IDLE and DRAIN.
REQ-015 In IDLE, en_y=1 SHALL capture all N_RES words of acc_in into an internal buffer, set idx=0, and move the FSM to DRAIN.
REQ-016 Latency SHALL be one cycle: en_y high at edge T gives y_valid=1 with y_data=acc_in word 0 (as sampled at T) after edge T.
REQ-017 In DRAIN, y_valid SHALL equal 1, y_data SHALL equal buf[idx], and y_last SHALL equal 1 exactly when idx equals N_RES-1.
REQ-018 A handshake SHALL occur when y_valid and y_ready are both 1 at a rising edge, and only a handshake SHALL advance idx by one.
REQ-019 While y_ready=0, y_data, y_last and idx SHALL remain stable.
REQ-020 A handshake with idx=N_RES-1 and en_y=0 SHALL return the FSM to IDLE, with y_valid=0 on the next cycle.
REQ-021 A handshake with idx=N_RES-1 and en_y=1 in the same cycle SHALL recapture acc_in, set idx=0, and keep the FSM in DRAIN, so y_valid stays 1 with no bubble.
REQ-022 en_y=1 in DRAIN outside the case of REQ-021 SHALL be ignored for data purposes, SHALL leave the buffer unchanged, and SHALL set overrun=1.
REQ-023 overrun SHALL stay at 1 until clr_overrun=1 or reset, and a set event SHALL take priority over clr_overrun in the same cycle.
REQ-024 The idx counter SHALL be $clog2(N_RES) bits wide, SHALL wrap only through the REQ-020 and REQ-021 transitions, and SHALL never exceed N_RES-1.
REQ-025 In IDLE, y_data SHALL be driven to 0, and y_valid and y_last SHALL be 0.
REQ-026 busy SHALL equal 1 exactly when the state is DRAIN.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, idx=0, buffer=0, y_valid=0, y_last=0, y_data=0, busy=0 and overrun=0.
REQ-028 Reset asserted in the middle of a drain SHALL discard the remaining words, and the block SHALL NOT resume that drain after reset is released.
REQ-029 The block SHALL sample en_y only on the first rising edge after reset is deasserted or later.

Structure
REQ-030 The state enum (IDLE, DRAIN) and the default DATA_W and N_RES constants SHALL reside in the shared package systolic_pkg.
REQ-031 The block SHALL be a single module with no sub-modules, with the buffer implemented as a register array inside result_drain.

Verification
REQ-032 The bench SHALL apply en_y with acc_in words 1..8 and y_ready held at 1, and SHALL observe y_data 1..8 on 8 consecutive cycles starting at T+1, with y_last only on 8 and IDLE afterwards.
REQ-033 The bench SHALL drive y_ready=0 for 3 cycles at idx=2, and SHALL observe y_data=3 held stable with y_valid=1, then the remaining words in order.
REQ-034 The bench SHALL pulse en_y at idx=4, and SHALL observe overrun=1 while the 8 original words complete unchanged; clr_overrun=1 SHALL then return overrun to 0.
REQ-035 The bench SHALL pulse en_y with new words 9..16 in the same cycle as the word-8 handshake, and SHALL observe 9 on the next cycle with no y_valid gap and overrun=0.
REQ-036 The bench SHALL assert reset at idx=5, and SHALL observe all outputs at 0 immediately and the FSM in IDLE after release, with no further words.
